// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: soft-start/soft-stop duty ramp, reversal dead-time and over-current latch for the motor bridge.
// Latency: every output is registered; a new command first changes the outputs 1 clk later, and ramp steps fire every TICK_DIV clk.
// Backpressure: none; the inputs are sampled every cycle, and a reset or a filtered over-current overrides any ramp in progress.
// Ports: clk/reset (sync, active-high); cmd speed 0..15 (target = cmd*255); dir per motor (0=fwd);
//        OC per-motor over-current; clear fault-clear level; duty 12-bit to pwm; IN/EN bridge drive;
//        fault latched over-current; state IDLE=0 RAMP_UP=1 RUN=2 RAMP_DOWN=3 DEAD=4 FAULT=5.
module motor_ramp_ctrl #(
    parameter int TICK_DIV  = 1000,
    parameter int STEP      = 15,
    parameter int DEAD_CYC  = 5000,
    parameter int OC_FILTER = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  cmd,
    input  logic [1:0]  dir,
    input  logic [1:0]  OC,
    input  logic        clear,
    output logic [11:0] duty,
    output logic [3:0]  IN,
    output logic [1:0]  EN,
    output logic        fault,
    output logic [2:0]  state
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        RUN       = 3'd2,
        RAMP_DOWN = 3'd3,
        DEAD      = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam int OW = $clog2(OC_FILTER + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYC - 1);
    localparam logic [OW-1:0] OC_LAST   = OW'(OC_FILTER - 1);
    localparam logic [11:0]   STEP12    = 12'(STEP);
    localparam logic [12:0]   STEP13    = 13'(STEP);

    state_t        state_q, state_n;
    logic [TW-1:0] tick_q, tick_n;
    logic [DW-1:0] dead_q, dead_n;
    logic [OW-1:0] oc_q, oc_n;
    logic [1:0]    dir_q, dir_n;
    logic          pend_q, pend_n;
    logic [11:0]   duty_n;
    logic          fault_n;

    logic [11:0] target, goal, up_val, down_val;
    logic [12:0] up_sum;
    logic        dir_chg, step, pend_eff, oc_trip, drive;

    // 12 bits suffice: 15*255 = 3825.
    assign target   = {8'd0, cmd} * 12'd255;
    assign dir_chg  = (dir != dir_q);
    assign step     = (tick_q == TICK_LAST);
    // A reversal seen in this very cycle already forces the ramp-down goal to 0.
    assign pend_eff = pend_q | dir_chg;
    assign goal     = pend_eff ? 12'd0 : target;
    // One extra bit so duty+STEP cannot wrap before the clamp against target.
    assign up_sum   = {1'b0, duty} + STEP13;
    assign up_val   = (up_sum >= {1'b0, target}) ? target : up_sum[11:0];
    assign down_val = ({1'b0, duty} > ({1'b0, goal} + STEP13)) ? (duty - STEP12) : goal;
    assign oc_trip  = (OC != 2'b00) && (oc_q == OC_LAST);

    always_comb begin
        state_n = state_q;
        duty_n  = duty;
        pend_n  = pend_q;
        dir_n   = dir_q;
        fault_n = fault;
        tick_n  = step ? '0 : tick_q + TW'(1);
        dead_n  = dead_q;
        oc_n    = (OC == 2'b00) ? '0 : ((oc_q == OC_LAST) ? oc_q : oc_q + OW'(1));

        case (state_q)
            IDLE: begin
                duty_n = 12'd0;
                if (target != 12'd0) begin
                    dir_n   = dir;
                    state_n = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (dir_chg) begin
                    pend_n  = 1'b1;
                    state_n = RAMP_DOWN;
                end else if (target < duty) begin
                    state_n = RAMP_DOWN;
                end else if (target == duty) begin
                    state_n = RUN;
                end else if (step) begin
                    duty_n = up_val;
                    if (up_val == target) state_n = RUN;
                end
            end
            RUN: begin
                if (dir_chg) begin
                    pend_n  = 1'b1;
                    state_n = RAMP_DOWN;
                end else if (target > duty) begin
                    state_n = RAMP_UP;
                end else if (target < duty) begin
                    state_n = RAMP_DOWN;
                end
            end
            RAMP_DOWN: begin
                pend_n = pend_eff;
                if (duty == goal) begin
                    state_n = pend_eff ? DEAD : ((goal == 12'd0) ? IDLE : RUN);
                end else if (goal > duty) begin
                    // Command raised above the current duty mid ramp-down.
                    state_n = RAMP_UP;
                end else if (step) begin
                    duty_n = down_val;
                    if (down_val == goal)
                        state_n = pend_eff ? DEAD : ((goal == 12'd0) ? IDLE : RUN);
                end
            end
            DEAD: begin
                duty_n = 12'd0;
                if (dead_q == DEAD_LAST) begin
                    dir_n   = dir;
                    pend_n  = 1'b0;
                    state_n = (target != 12'd0) ? RAMP_UP : IDLE;
                end else begin
                    dead_n = dead_q + DW'(1);
                end
            end
            FAULT: begin
                duty_n  = 12'd0;
                fault_n = 1'b1;
                if (clear && (OC == 2'b00)) begin
                    state_n = IDLE;
                    fault_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Over-current wins over every other transition, including clear.
        if (oc_trip) begin
            state_n = FAULT;
            duty_n  = 12'd0;
            pend_n  = 1'b0;
            fault_n = 1'b1;
        end

        if (state_n != state_q) begin
            tick_n = '0;
            dead_n = '0;
        end
    end

    assign drive = (state_n == RAMP_UP) || (state_n == RUN) || (state_n == RAMP_DOWN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            dead_q  <= '0;
            oc_q    <= '0;
            dir_q   <= 2'b00;
            pend_q  <= 1'b0;
            duty    <= 12'd0;
            IN      <= 4'b0000;
            EN      <= 2'b00;
            fault   <= 1'b0;
        end else begin
            state_q <= state_n;
            tick_q  <= tick_n;
            dead_q  <= dead_n;
            oc_q    <= oc_n;
            dir_q   <= dir_n;
            pend_q  <= pend_n;
            duty    <= duty_n;
            fault   <= fault_n;
            // Per motor: dir 0 -> 2'b10, dir 1 -> 2'b01; bridge off outside the driving states.
            IN      <= drive ? {~dir_n[1], dir_n[1], ~dir_n[0], dir_n[0]} : 4'b0000;
            EN      <= drive ? 2'b11 : 2'b00;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: table-driven vectors, corner sequences and randomized run against a reference model.
// Latency: outputs are sampled on the falling edge after each rising edge.
// Backpressure: none; the stimulus is free-running.
module tb_motor_ramp_ctrl;
    localparam int TDIV  = 4;
    localparam int STP   = 255;
    localparam int DEADC = 8;
    localparam int OCF   = 3;

    localparam int S_IDLE = 0, S_UP = 1, S_RUN = 2, S_DN = 3, S_DEAD = 4, S_FLT = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  cmd = 4'd0;
    logic [1:0]  dir = 2'd0;
    logic [1:0]  OC = 2'd0;
    logic        clear = 1'b0;
    logic [11:0] duty;
    logic [3:0]  IN;
    logic [1:0]  EN;
    logic        fault;
    logic [2:0]  state;

    logic        reset2 = 1'b1;
    logic [3:0]  cmd2 = 4'd0;
    logic [1:0]  dir2 = 2'd0;
    logic [1:0]  oc2 = 2'd0;
    logic        clear2 = 1'b0;
    logic [11:0] duty2;
    logic [3:0]  in2;
    logic [1:0]  en2;
    logic        fault2;
    logic [2:0]  state2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.TICK_DIV(TDIV), .STEP(STP), .DEAD_CYC(DEADC), .OC_FILTER(OCF)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .dir(dir), .OC(OC), .clear(clear),
        .duty(duty), .IN(IN), .EN(EN), .fault(fault), .state(state)
    );

    motor_ramp_ctrl #(.TICK_DIV(TDIV), .STEP(1000), .DEAD_CYC(DEADC), .OC_FILTER(OCF)) dut2 (
        .clk(clk), .reset(reset2), .cmd(cmd2), .dir(dir2), .OC(oc2), .clear(clear2),
        .duty(duty2), .IN(in2), .EN(en2), .fault(fault2), .state(state2)
    );

    typedef struct {
        int n; int rst; int c; int d; int oc; int clr;
        int duty; int inb; int en; int flt; int st;
    } vec_t;

    typedef struct { int st; int duty; int dirl; int pend; int age; int ocrun; } mdl_t;

    function automatic vec_t mk(int n, int rst, int c, int d, int oc, int clr,
                                int du, int inb, int en, int flt, int st);
        vec_t v;
        v.n = n; v.rst = rst; v.c = c; v.d = d; v.oc = oc; v.clr = clr;
        v.duty = du; v.inb = inb; v.en = en; v.flt = flt; v.st = st;
        return v;
    endfunction

    function automatic logic [21:0] pack(int du, int inb, int en, int flt, int st);
        return {12'(du), 4'(inb), 2'(en), 1'(flt), 3'(st)};
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got duty=%0d IN=%b EN=%b fault=%b state=%0d, want duty=%0d IN=%b EN=%b fault=%b state=%0d",
                     name, act[21:10], act[9:6], act[5:4], act[3], act[2:0],
                     exp[21:10], exp[9:6], exp[5:4], exp[3], exp[2:0]);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: time in state is an age counter, steps fall on age multiples,
    // the over-current filter is a plain run length.
    function automatic mdl_t mstep(mdl_t m, int rst, int c, int d, int oc, int clr, int stp);
        mdl_t n;
        int tgt, goal;
        bit tk, chg, p;
        n = m;
        if (rst != 0) begin
            n = '{0, 0, 0, 0, 0, 0};
            return n;
        end
        tgt = c * 255;
        chg = (d != m.dirl);
        tk  = (m.age % TDIV) == TDIV - 1;
        n.ocrun = (oc != 0) ? m.ocrun + 1 : 0;
        case (m.st)
            S_IDLE: begin
                n.duty = 0;
                if (tgt > 0) begin n.st = S_UP; n.dirl = d; end
            end
            S_UP: begin
                if (chg) begin n.pend = 1; n.st = S_DN; end
                else if (tgt < m.duty) n.st = S_DN;
                else if (tgt == m.duty) n.st = S_RUN;
                else if (tk) begin
                    n.duty = (m.duty + stp > tgt) ? tgt : m.duty + stp;
                    if (n.duty == tgt) n.st = S_RUN;
                end
            end
            S_RUN: begin
                if (chg) begin n.pend = 1; n.st = S_DN; end
                else if (tgt > m.duty) n.st = S_UP;
                else if (tgt < m.duty) n.st = S_DN;
            end
            S_DN: begin
                p = (m.pend != 0) || chg;
                n.pend = p ? 1 : 0;
                goal = p ? 0 : tgt;
                if (m.duty == goal) n.st = p ? S_DEAD : (goal == 0 ? S_IDLE : S_RUN);
                else if (goal > m.duty) n.st = S_UP;
                else if (tk) begin
                    n.duty = (m.duty - stp < goal) ? goal : m.duty - stp;
                    if (n.duty == goal) n.st = p ? S_DEAD : (goal == 0 ? S_IDLE : S_RUN);
                end
            end
            S_DEAD: begin
                n.duty = 0;
                if (m.age == DEADC - 1) begin
                    n.dirl = d;
                    n.pend = 0;
                    n.st = (tgt > 0) ? S_UP : S_IDLE;
                end
            end
            default: begin
                n.duty = 0;
                if (clr != 0 && oc == 0) n.st = S_IDLE;
            end
        endcase
        if (n.ocrun >= OCF) begin n.st = S_FLT; n.duty = 0; n.pend = 0; end
        n.age = (n.st != m.st) ? 0 : m.age + 1;
        return n;
    endfunction

    function automatic logic [21:0] mout(mdl_t m);
        int inb, en;
        inb = 0; en = 0;
        if (m.st >= S_UP && m.st <= S_DN) begin
            en  = 3;
            inb = (((m.dirl & 2) != 0) ? 4 : 8) + (((m.dirl & 1) != 0) ? 1 : 2);
        end
        return pack(m.duty, inb, en, (m.st == S_FLT) ? 1 : 0, m.st);
    endfunction

    vec_t tv[23];
    mdl_t mdl;
    int   ocleft, ocv;

    initial begin
        tv[0]  = mk( 2, 1, 0, 0, 0, 0,    0, 4'b0000, 0, 0, 0);
        tv[1]  = mk( 1, 0, 9, 0, 0, 0,    0, 4'b1010, 3, 0, 1);
        tv[2]  = mk( 4, 0, 9, 0, 0, 0,  255, 4'b1010, 3, 0, 1);
        tv[3]  = mk(31, 0, 9, 0, 0, 0, 2040, 4'b1010, 3, 0, 1);
        tv[4]  = mk( 1, 0, 9, 0, 0, 0, 2295, 4'b1010, 3, 0, 2);
        tv[5]  = mk( 5, 0, 9, 0, 0, 0, 2295, 4'b1010, 3, 0, 2);
        tv[6]  = mk( 1, 0, 3, 0, 0, 0, 2295, 4'b1010, 3, 0, 3);
        tv[7]  = mk(23, 0, 3, 0, 0, 0, 1020, 4'b1010, 3, 0, 3);
        tv[8]  = mk( 1, 0, 3, 0, 0, 0,  765, 4'b1010, 3, 0, 2);
        tv[9]  = mk( 1, 0, 3, 3, 0, 0,  765, 4'b1010, 3, 0, 3);
        tv[10] = mk(11, 0, 3, 3, 0, 0,  255, 4'b1010, 3, 0, 3);
        tv[11] = mk( 1, 0, 3, 3, 0, 0,    0, 4'b0000, 0, 0, 4);
        tv[12] = mk( 7, 0, 3, 3, 0, 0,    0, 4'b0000, 0, 0, 4);
        tv[13] = mk( 1, 0, 3, 3, 0, 0,    0, 4'b0101, 3, 0, 1);
        tv[14] = mk(12, 0, 3, 3, 0, 0,  765, 4'b0101, 3, 0, 2);
        tv[15] = mk( 2, 0, 3, 3, 1, 0,  765, 4'b0101, 3, 0, 2);
        tv[16] = mk( 1, 0, 3, 3, 0, 0,  765, 4'b0101, 3, 0, 2);
        tv[17] = mk( 2, 0, 3, 3, 2, 0,  765, 4'b0101, 3, 0, 2);
        tv[18] = mk( 1, 0, 3, 3, 2, 0,    0, 4'b0000, 0, 1, 5);
        tv[19] = mk( 3, 0, 3, 3, 2, 1,    0, 4'b0000, 0, 1, 5);
        tv[20] = mk( 2, 0, 3, 3, 0, 0,    0, 4'b0000, 0, 1, 5);
        tv[21] = mk( 1, 0, 3, 3, 0, 1,    0, 4'b0000, 0, 0, 0);
        tv[22] = mk( 1, 0, 3, 3, 0, 0,    0, 4'b0101, 3, 0, 1);

        for (int i = 0; i < 23; i++) begin
            reset = 1'(tv[i].rst);
            cmd   = 4'(tv[i].c);
            dir   = 2'(tv[i].d);
            OC    = 2'(tv[i].oc);
            clear = 1'(tv[i].clr);
            run(tv[i].n);
            check($sformatf("vec%0d", i), {duty, IN, EN, fault, state},
                  pack(tv[i].duty, tv[i].inb, tv[i].en, tv[i].flt, tv[i].st));
        end

        // Reset in the middle of a ramp-up.
        run(6);
        check("ramp_before_reset", {duty, IN, EN, fault, state}, pack(255, 4'b0101, 3, 0, 1));
        reset = 1'b1;
        run(1);
        check("reset_mid_ramp", {duty, IN, EN, fault, state}, pack(0, 0, 0, 0, 0));
        reset = 1'b0;
        run(1);
        check("restart_after_reset", {duty, IN, EN, fault, state}, pack(0, 4'b0101, 3, 0, 1));

        // Large step: clamp exactly on target, and no wrap at cmd=15.
        reset2 = 1'b0;
        cmd2   = 4'd9;
        run(1);
        check("big_entry", {duty2, in2, en2, fault2, state2}, pack(0, 4'b1010, 3, 0, 1));
        run(4);
        check("big_1000", {duty2, in2, en2, fault2, state2}, pack(1000, 4'b1010, 3, 0, 1));
        run(4);
        check("big_2000", {duty2, in2, en2, fault2, state2}, pack(2000, 4'b1010, 3, 0, 1));
        run(4);
        check("big_clamp2295", {duty2, in2, en2, fault2, state2}, pack(2295, 4'b1010, 3, 0, 2));
        cmd2 = 4'd15;
        run(1);
        check("big_reup", {duty2, in2, en2, fault2, state2}, pack(2295, 4'b1010, 3, 0, 1));
        run(4);
        check("big_3295", {duty2, in2, en2, fault2, state2}, pack(3295, 4'b1010, 3, 0, 1));
        run(4);
        check("big_clamp3825", {duty2, in2, en2, fault2, state2}, pack(3825, 4'b1010, 3, 0, 2));
        run(3);
        check("big_hold3825", {duty2, in2, en2, fault2, state2}, pack(3825, 4'b1010, 3, 0, 2));

        // Randomized run against the reference model.
        mdl = '{0, 0, 0, 0, 0, 0};
        ocleft = 0;
        ocv = 0;
        for (int i = 0; i < 3000; i++) begin
            reset = (i == 0) || ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 19) == 0) cmd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) dir = 2'($urandom_range(0, 3));
            if (ocleft > 0) ocleft--;
            else if ($urandom_range(0, 99) == 0) begin
                ocleft = $urandom_range(1, 5);
                ocv = $urandom_range(1, 3);
            end
            OC    = (ocleft > 0) ? 2'(ocv) : 2'd0;
            clear = ($urandom_range(0, 3) == 0);
            mdl = mstep(mdl, int'(reset), int'(cmd), int'(dir), int'(OC), int'(clear), STP);
            run(1);
            check($sformatf("rand%0d", i), {duty, IN, EN, fault, state}, mout(mdl));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
